if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives the instruction-memory request handshake, and owns the IF/ID pipeline register consumed by the ID stage and the hazard-detection unit. It honours the hazard unit's PC/IF-ID write enables for load-use stalls. It also honours ID-stage branch/jump redirects, which flush IF/ID. A one-entry hold buffer absorbs instructions that return while the pipeline is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP, 32'h0000_0000, instruction word inserted into IF/ID on bubble/flush

- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- PCWrite_i  in  1  1 = PC may advance (from hazard detection)
- IFIDWrite_i  in  1  1 = IF/ID may load (from hazard detection)
- branch_i  in  1  taken branch resolved in ID
- branch_target_i  in  32  branch target
- jump_i  in  1  jump decoded in ID
- jump_target_i  in  32  jump target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address; stable while request pending
- imem_ready_i  in  1  data valid this cycle; completes the request
- imem_data_i  in  32  instruction word, valid when imem_ready_i=1
- instr_o  out  32  IF/ID instruction
- pc4_o  out  32  IF/ID PC+4 of instr_o
- valid_o  out  1  IF/ID holds a real instruction

## Operation
- State registers: pc, fetch_addr, kill, hold_instr/hold_pc4, FSM state.
- FSM states:
  - IDLE: entered only from reset. Next cycle goes to REQ with fetch_addr=pc.
  - REQ: imem_req_o=1, imem_addr_o=fetch_addr.
  - HOLD: imem_req_o=0. hold buffer full.
- Redirect = branch_i | jump_i. If both are set, branch wins. Redirect has priority over stall: it flushes IF/ID even when IFIDWrite_i=0.
- REQ with imem_ready_i=1 and kill=0:
  - If redirect: discard data, pc=target, IF/ID←NOP/valid 0, start new REQ at target.
  - Else if PCWrite_i & IFIDWrite_i: IF/ID←{imem_data_i, fetch_addr+4, valid 1}, pc=fetch_addr+4, new REQ at pc.
  - Else: hold buffer←{data, fetch_addr+4}, go HOLD. IF/ID keeps its value unless IFIDWrite_i=1, in which case it gets NOP/valid 0.
- REQ with imem_ready_i=1 and kill=1: discard data, clear kill, start new REQ at pc (the redirect target).
- REQ with imem_ready_i=0:
  - Address stays stable.
  - Redirect: pc=target, kill=1, IF/ID←NOP/valid 0.
  - No redirect: IF/ID←NOP/valid 0 if IFIDWrite_i=1, else holds.
- HOLD:
  - Redirect: drop buffer, pc=target, IF/ID←NOP/valid 0, REQ at target.
  - Else if PCWrite_i & IFIDWrite_i: IF/ID←buffer, pc=hold_pc4, REQ at pc.
  - Else: remain; IF/ID holds.
- Arithmetic: PC+4 is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. No alignment check.

## Timing
- Reset (async assert, sync-safe deassert):
  - pc=RESET_PC, fetch_addr=RESET_PC.
  - instr_o=NOP, pc4_o=0, valid_o=0.
  - imem_req_o=0, kill=0, state=IDLE.
- First request: imem_req_o rises on the first edge after rst_n_i deasserts.
- Zero-wait memory (ready same cycle as request): the instruction appears on instr_o one edge later. Throughput is 1 instr/cycle with back-to-back requests.
- N-wait memory: the instruction appears one edge after the ready cycle. Bubbles (valid 0) are inserted for each waiting cycle when IFIDWrite_i=1.
- Redirect latency: the target address is on imem_addr_o the cycle after redirect, unless a killed request is still pending. In that case it is driven the cycle after that request's ready.
- Reset mid-request: the request is abandoned immediately, with no handshake completion required.

## Test plan
- Reset then zero-wait memory returning 32'h2001_0005, 32'h2002_0007 -> imem_addr_o 0,4,8. instr_o shows each word one cycle after, pc4_o 4,8. valid_o=1.
- Memory waits 2 cycles on addr 0 -> two valid_o=0 bubbles, then instr_o=word, pc4_o=4. imem_addr_o stays 0 throughout the wait.
- Stall: PCWrite_i=IFIDWrite_i=0 for 1 cycle while ready returns addr 8 -> HOLD, imem_req_o=0, IF/ID unchanged. Next cycle (enables=1): instr_o=buffered word, pc4_o=12, fetch resumes at 12.
- branch_i=1, target 32'h40, during a pending 3-cycle wait -> valid_o=0 next edge. The pending data is discarded, the next request is at 32'h40, and the first valid instr has pc4_o=32'h44.
- branch_i and jump_i together (targets 32'h80/32'hC0) with IFIDWrite_i=0 -> branch wins, fetch at 32'h80, IF/ID flushed to NOP/valid 0.
- pc=32'hFFFF_FFFC fetched -> pc4_o=0, next imem_addr_o=0. Assert rst_n_i low mid-wait -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request handshake, IF/ID register
// and a one-entry hold buffer for data returning during a stall.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        PCWrite_i,
  input  logic        IFIDWrite_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } hold_t;

  localparam ifid_t BUBBLE = '{instr: NOP, pc4: 32'h0, valid: 1'b0};

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_addr, fetch_addr_n;
  logic        kill, kill_n;
  hold_t       hold, hold_n;
  ifid_t       ifid, ifid_n;

  logic        redirect;
  logic [31:0] target;
  logic        advance;
  logic [31:0] seq_pc4;

  // Branch beats jump when both arrive together.
  assign redirect = branch_i | jump_i;
  assign target   = branch_i ? branch_target_i : jump_target_i;
  assign advance  = PCWrite_i & IFIDWrite_i;
  assign seq_pc4  = fetch_addr + 32'd4;   // modulo 2^32 wrap is intended

  assign imem_req_o  = (state == S_REQ);
  assign imem_addr_o = fetch_addr;
  assign instr_o     = ifid.instr;
  assign pc4_o       = ifid.pc4;
  assign valid_o     = ifid.valid;

  // State register: async reset abandons any outstanding request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      kill       <= 1'b0;
      hold       <= '0;
      ifid       <= BUBBLE;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      fetch_addr <= fetch_addr_n;
      kill       <= kill_n;
      hold       <= hold_n;
      ifid       <= ifid_n;
    end
  end

  // Next-state: redirect outranks stall; a pending request keeps its address
  // and is marked killed instead of being cancelled.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    fetch_addr_n = fetch_addr;
    kill_n       = kill;
    hold_n       = hold;
    ifid_n       = ifid;
    case (state)
      S_IDLE: begin
        state_n      = S_REQ;
        fetch_addr_n = pc;
      end
      S_REQ: begin
        if (imem_ready_i) begin
          if (kill) begin
            // Stale data for a redirected fetch; restart at the current pc.
            kill_n = 1'b0;
            if (redirect) begin
              pc_n         = target;
              fetch_addr_n = target;
              ifid_n       = BUBBLE;
            end else begin
              fetch_addr_n = pc;
              if (IFIDWrite_i) ifid_n = BUBBLE;
            end
          end else if (redirect) begin
            pc_n         = target;
            fetch_addr_n = target;
            ifid_n       = BUBBLE;
          end else if (advance) begin
            ifid_n       = '{instr: imem_data_i, pc4: seq_pc4, valid: 1'b1};
            pc_n         = seq_pc4;
            fetch_addr_n = seq_pc4;
          end else begin
            hold_n  = '{instr: imem_data_i, pc4: seq_pc4};
            state_n = S_HOLD;
            if (IFIDWrite_i) ifid_n = BUBBLE;
          end
        end else begin
          if (redirect) begin
            pc_n   = target;
            kill_n = 1'b1;
            ifid_n = BUBBLE;
          end else if (IFIDWrite_i) begin
            ifid_n = BUBBLE;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n         = target;
          fetch_addr_n = target;
          ifid_n       = BUBBLE;
          state_n      = S_REQ;
        end else if (advance) begin
          ifid_n       = '{instr: hold.instr, pc4: hold.pc4, valid: 1'b1};
          pc_n         = hold.pc4;
          fetch_addr_n = hold.pc4;
          state_n      = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by a randomized run, checked
// against a program-order model (next expected PC, redirect resets it).
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        PCWrite_i, IFIDWrite_i;
  logic        branch_i, jump_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o, pc4_o;
  logic        valid_o;

  if_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .PCWrite_i(PCWrite_i), .IFIDWrite_i(IFIDWrite_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i),
    .instr_o(instr_o), .pc4_o(pc4_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  int          tests = 0;
  int          fails = 0;
  int          wait_left;     // wait cycles left on the current request
  int          nwait;         // wait count given to the next request
  bit          rnd_wait = 0;
  logic [31:0] exp_pc;        // address of the next instruction due in IF/ID
  int          ndeliv = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs and memory at negedge, check #1 after posedge.
  task automatic step(input logic b, input logic [31:0] bt, input logic j,
                      input logic [31:0] jt, input logic en);
    logic [31:0] p_instr, p_pc4, p_addr, tgt;
    logic        p_valid, p_req, p_rdy, redir;
    branch_i = b; branch_target_i = bt;
    jump_i = j;   jump_target_i = jt;
    PCWrite_i = en; IFIDWrite_i = en;
    p_req = imem_req_o; p_addr = imem_addr_o;
    if (imem_req_o && wait_left == 0) begin
      imem_ready_i = 1'b1;
      imem_data_i  = word(imem_addr_o);
    end else begin
      imem_ready_i = 1'b0;
      imem_data_i  = $urandom;
      if (imem_req_o) wait_left--;
    end
    p_rdy = imem_ready_i;
    p_instr = instr_o; p_pc4 = pc4_o; p_valid = valid_o;
    redir = b | j;
    tgt   = b ? bt : jt;
    @(posedge clk_i); #1;
    if (p_req && p_rdy) wait_left = rnd_wait ? int'($urandom_range(0, 3)) : nwait;
    if (redir) begin
      chk("flush_valid", {31'd0, valid_o}, 32'd0);
      exp_pc = tgt;
    end else if (en) begin
      if (valid_o) begin
        chk("seq_pc4", pc4_o, exp_pc + 32'd4);
        chk("seq_instr", instr_o, word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ndeliv++;
      end
    end else begin
      chk("stall_instr", instr_o, p_instr);
      chk("stall_pc4", pc4_o, p_pc4);
      chk("stall_valid", {31'd0, valid_o}, {31'd0, p_valid});
    end
    if (p_req && !p_rdy && imem_req_o) chk("addr_stable", imem_addr_o, p_addr);
    @(negedge clk_i);
  endtask

  task automatic go(input logic en);
    step(1'b0, 32'h0, 1'b0, 32'h0, en);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr"}, instr_o, 32'h0);
    chk({tag, "_pc4"}, pc4_o, 32'h0);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
  endtask

  initial begin
    logic [31:0] r, t1, t2;
    rst_n_i = 1'b0;
    PCWrite_i = 1'b1; IFIDWrite_i = 1'b1;
    branch_i = 1'b0; jump_i = 1'b0;
    branch_target_i = '0; jump_target_i = '0;
    imem_ready_i = 1'b0; imem_data_i = '0;
    nwait = 0; wait_left = 0; exp_pc = 32'h0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;

    // Zero-wait stream: addresses 0,4,8 back to back.
    go(1'b1);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);
    go(1'b1);
    chk("zw_addr4", imem_addr_o, 32'h4);
    chk("zw_pc4_4", pc4_o, 32'h4);
    go(1'b1);
    chk("zw_addr8", imem_addr_o, 32'h8);
    chk("zw_pc4_8", pc4_o, 32'h8);
    chk("zw_valid", {31'd0, valid_o}, 32'd1);

    // Stall while addr 8 returns: HOLD, then buffered word released.
    go(1'b0);
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    go(1'b1);
    chk("hold_pc4", pc4_o, 32'd12);
    chk("hold_instr", instr_o, word(32'h8));
    chk("resume_addr", imem_addr_o, 32'd12);

    // Branch to 0x40 while a 3-cycle wait is pending.
    nwait = 3;
    go(1'b1);
    nwait = 0;
    step(1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    go(1'b1); go(1'b1); go(1'b1);
    chk("br_addr", imem_addr_o, 32'h40);
    go(1'b1);
    chk("br_pc4", pc4_o, 32'h44);
    chk("br_valid", {31'd0, valid_o}, 32'd1);

    // Branch and jump together with IF/ID write disabled: branch wins.
    step(1'b1, 32'h80, 1'b1, 32'hC0, 1'b0);
    chk("bj_addr", imem_addr_o, 32'h80);
    chk("bj_instr", instr_o, 32'h0);
    go(1'b1);
    chk("bj_pc4", pc4_o, 32'h84);

    // Wrap at the top of the address space.
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    go(1'b1);
    chk("wrap_pc4", pc4_o, 32'h0);
    chk("wrap_addr", imem_addr_o, 32'h0);

    // Reset in the middle of a wait, off the clock edge.
    nwait = 5;
    go(1'b1);
    go(1'b1); go(1'b1);
    #2 rst_n_i = 1'b0;
    #1 chk_reset_outputs("async_rst");
    nwait = 2; wait_left = 2; exp_pc = 32'h0;
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Two-wait memory on address 0: two bubbles, address held.
    go(1'b1);
    go(1'b1);
    chk("w2_bub1", {31'd0, valid_o}, 32'd0);
    chk("w2_addr1", imem_addr_o, 32'h0);
    go(1'b1);
    chk("w2_bub2", {31'd0, valid_o}, 32'd0);
    chk("w2_addr2", imem_addr_o, 32'h0);
    go(1'b1);
    chk("w2_pc4", pc4_o, 32'h4);
    chk("w2_valid", {31'd0, valid_o}, 32'd1);

    // Randomized run: random waits, stalls and redirects.
    rnd_wait = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r  = $urandom_range(0, 24);
      t1 = $urandom; t1[1:0] = 2'b00;
      t2 = $urandom; t2[1:0] = 2'b00;
      step(r == 0 || r == 2, t1, r == 1 || r == 2, t2, $urandom_range(0, 3) != 0);
    end
    tests++;
    assert (ndeliv > 300) else begin
      fails++;
      $error("FAIL progress: observed %0d deliveries expected more than 300", ndeliv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
